// File: rtl/bsg_counter_window_sampler.sv
// Windowed popcount event counter: sums popcount(up_i) over window_p counting
// cycles and offers each window total on a valid/yumi output slot.
module bsg_counter_window_sampler #(
  parameter  int els_p          = 4,
  parameter  int window_p       = 256,
  localparam int count_width_lp = $clog2(window_p*els_p + 1),
  localparam int win_width_lp   = (window_p > 1) ? $clog2(window_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic [els_p-1:0]          up_i,
  output logic                      v_o,
  output logic [count_width_lp-1:0] count_o,
  input  logic                      yumi_i,
  output logic                      overrun_o,
  output logic                      busy_o
);

  localparam int pop_width_lp = $clog2(els_p + 1);

  if (window_p < 2) begin : g_window_check
    $error("bsg_counter_window_sampler: window_p must be >= 2");
  end

  typedef enum logic [0:0] {eIdle, eCount} state_e;

  state_e                    state, state_n;
  logic [count_width_lp-1:0] acc;
  logic [win_width_lp-1:0]   win;
  logic [pop_width_lp-1:0]   pop;
  logic [count_width_lp-1:0] sample;
  logic                      counting;
  logic                      window_end;
  logic                      accept;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a variable unassigned and no latch forms.
  always_comb begin
    pop = '0;
    for (int i = 0; i < els_p; i++) begin
      pop = pop + pop_width_lp'(up_i[i]);
    end
  end

  assign counting   = (state == eCount) && en_i;
  assign window_end = counting && (win == win_width_lp'(window_p - 1));
  assign sample     = acc + count_width_lp'(pop);
  // A slot freed by yumi on the window-end cycle can take the new sample.
  assign accept     = window_end && (!v_o || yumi_i);
  assign busy_o     = (state == eCount);

  always_comb begin
    state_n = state;
    case (state)
      eIdle:   if (en_i)  state_n = eCount;
      eCount:  if (!en_i) state_n = eIdle;
      default: state_n = eIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= eIdle;
    end else begin
      state <= state_n;
    end
  end

  // Leaving eCount (or sitting in eIdle) keeps the accumulator empty, so a
  // partial window is discarded and the next window starts fresh.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc <= '0;
      win <= '0;
    end else if (window_end) begin
      acc <= '0;
      win <= '0;
    end else if (counting) begin
      acc <= sample;
      win <= win + 1'b1;
    end else begin
      acc <= '0;
      win <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o       <= 1'b0;
      count_o   <= '0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= window_end && v_o && !yumi_i;
      if (accept) begin
        v_o     <= 1'b1;
        count_o <= sample;
      end else if (yumi_i) begin
        v_o <= 1'b0;
      end
    end
  end

  yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
  ) else $warning("bsg_counter_window_sampler: yumi_i asserted while v_o=0");

endmodule

// File: tb/tb_bsg_counter_window_sampler.sv
// Directed, table-driven bench for bsg_counter_window_sampler with els_p=4,
// window_p=8: each record gives one cycle's inputs and the outputs after its edge.
module tb_bsg_counter_window_sampler;

  localparam int els_lp    = 4;
  localparam int window_lp = 8;
  localparam int cw_lp     = $clog2(window_lp*els_lp + 1);

  logic              clk;
  logic              reset_i;
  logic              en_i;
  logic [els_lp-1:0] up_i;
  logic              v_o;
  logic [cw_lp-1:0]  count_o;
  logic              yumi_i;
  logic              overrun_o;
  logic              busy_o;

  bsg_counter_window_sampler #(
    .els_p   (els_lp),
    .window_p(window_lp)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .en_i     (en_i),
    .up_i     (up_i),
    .v_o      (v_o),
    .count_o  (count_o),
    .yumi_i   (yumi_i),
    .overrun_o(overrun_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              en;
    logic [els_lp-1:0] up;
    logic              yumi;
    logic              v;
    logic [cw_lp-1:0]  count;
    logic              ovr;
    logic              busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add_n(int n, logic en, logic [els_lp-1:0] up, logic yumi,
                                logic v, logic [cw_lp-1:0] count, logic ovr, logic busy);
    vec_t r;
    r.en = en; r.up = up; r.yumi = yumi;
    r.v = v; r.count = count; r.ovr = ovr; r.busy = busy;
    for (int i = 0; i < n; i++) vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    reset_i = 1'b0;
    en_i    = 1'b0;
    up_i    = '0;
    yumi_i  = 1'b0;

    // Window A: enable cycle not counted, then 8 x popcount 4 -> 32.
    add_n(1, 1, 4'b1111, 0, 0,  0, 0, 1);
    add_n(7, 1, 4'b1111, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b1111, 0, 1, 32, 0, 1);
    // Window B: consume A, stream continues -> 32 again.
    add_n(1, 1, 4'b1111, 1, 0,  0, 0, 1);
    add_n(6, 1, 4'b1111, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b1111, 0, 1, 32, 0, 1);
    // Window C: popcounts 1,2,0,3,4,1,1,2 -> 14.
    add_n(1, 1, 4'b0001, 1, 0,  0, 0, 1);
    add_n(1, 1, 4'b0011, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0000, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0111, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b1111, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0100, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b1000, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b1010, 0, 1, 14, 0, 1);
    // Window D: popcounts 4,0,...,0 -> 4.
    add_n(1, 1, 4'b1111, 1, 0,  0, 0, 1);
    add_n(6, 1, 4'b0000, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0000, 0, 1,  4, 0, 1);
    // Window E: 4+2+3+1 -> 10, accepted into the empty slot.
    add_n(1, 1, 4'b1111, 1, 0,  0, 0, 1);
    add_n(1, 1, 4'b0011, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0111, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0001, 0, 0,  0, 0, 1);
    add_n(3, 1, 4'b0000, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0000, 0, 1, 10, 0, 1);
    // Window F: total 20 with no yumi -> dropped, overrun pulses once.
    add_n(5, 1, 4'b1111, 0, 1, 10, 0, 1);
    add_n(2, 1, 4'b0000, 0, 1, 10, 0, 1);
    add_n(1, 1, 4'b0000, 0, 1, 10, 1, 1);
    // Window G: total 7, yumi on the window-end cycle -> slot refilled.
    add_n(1, 1, 4'b0111, 0, 1, 10, 0, 1);
    add_n(1, 1, 4'b1111, 0, 1, 10, 0, 1);
    add_n(5, 1, 4'b0000, 0, 1, 10, 0, 1);
    add_n(1, 1, 4'b0000, 1, 1,  7, 0, 1);
    // Window H: yumi drops v_o, en_i falls after 5 counting cycles.
    add_n(1, 1, 4'b1111, 1, 0,  0, 0, 1);
    add_n(4, 1, 4'b1111, 0, 0,  0, 0, 1);
    add_n(2, 0, 4'b1111, 0, 0,  0, 0, 0);
    // Re-enable: fresh window of 8 x popcount 1 -> 8.
    add_n(1, 1, 4'b1111, 0, 0,  0, 0, 1);
    add_n(7, 1, 4'b0001, 0, 0,  0, 0, 1);
    add_n(1, 1, 4'b0001, 0, 1,  8, 0, 1);

    // Asynchronous reset asserted mid-cycle must clear outputs before any edge.
    repeat (2) @(posedge clk);
    #3 reset_i = 1'b1;
    #1;
    check("reset_v",       32'(v_o),       32'd0);
    check("reset_overrun", 32'(overrun_o), 32'd0);
    check("reset_busy",    32'(busy_o),    32'd0);
    check("reset_count",   32'(count_o),   32'd0);
    repeat (2) @(posedge clk);
    #4 reset_i = 1'b0;

    // Disabled with all strobes high: no sample, not busy.
    up_i = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("idle_v",    32'(v_o),    32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
    end

    for (int k = 0; k < vecs.size(); k++) begin
      en_i   = vecs[k].en;
      up_i   = vecs[k].up;
      yumi_i = vecs[k].yumi;
      @(posedge clk); #1;
      check($sformatf("vec%0d_v", k),       32'(v_o),       32'(vecs[k].v));
      check($sformatf("vec%0d_overrun", k), 32'(overrun_o), 32'(vecs[k].ovr));
      check($sformatf("vec%0d_busy", k),    32'(busy_o),    32'(vecs[k].busy));
      if (vecs[k].v) check($sformatf("vec%0d_count", k), 32'(count_o), 32'(vecs[k].count));
    end

    // A held sample survives en_i deassertion until yumi.
    en_i = 1'b0; up_i = '0; yumi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_v",     32'(v_o),     32'd1);
    check("hold_count", 32'(count_o), 32'd8);
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    check("final_yumi_v", 32'(v_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
